// File: rtl/vdma_arb_pkg.sv
// Shared types and constants for the two-channel VDMA read arbiter.
package vdma_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_BUSY    = 2'd2,
      ST_RELEASE = 2'd3
   } arb_state_e;

   localparam int NUM_CH          = 2;
   localparam int TIMEOUT_CYC_DEF = 65535;
   localparam int LINE_W          = 24;
   localparam int COL_W           = 12;

endpackage

// File: rtl/vdma_arb_chan_latch.sv
// One channel's request capture: pending flag, captured frame fields and
// first-cycle detection of the channel's req_end (level or pulse).
module vdma_arb_chan_latch
   import vdma_arb_pkg::*;
#(
   parameter int ADDR_BITS = 25
) (
   input  logic                 pclk,
   input  logic                 prst,
   input  logic                 rd_req,
   input  logic [ADDR_BITS-1:0] baseaddr,
   input  logic [LINE_W-1:0]    line_length,
   input  logic [COL_W-1:0]     col_length,
   input  logic                 req_end,
   input  logic                 is_owner,
   input  logic                 grant_clr,
   output logic                 pending,
   output logic [ADDR_BITS-1:0] cap_baseaddr,
   output logic [LINE_W-1:0]    cap_line_length,
   output logic [COL_W-1:0]     cap_col_length,
   output logic                 end_pulse
);

   logic                 pending_r;
   logic [ADDR_BITS-1:0] base_r;
   logic [LINE_W-1:0]    line_r;
   logic [COL_W-1:0]     col_r;
   logic                 end_d_r;
   logic                 end_pulse_s;
   logic                 abort_s;

   assign end_pulse_s = req_end & ~end_d_r;
   assign abort_s     = end_pulse_s & ~is_owner;

   // A fresh request wins over grant-clear or abort so it is never lost.
   always_ff @(posedge pclk) begin
      if (prst) begin
         pending_r <= 1'b0;
         base_r    <= '0;
         line_r    <= '0;
         col_r     <= '0;
         end_d_r   <= 1'b0;
      end else begin
         end_d_r <= req_end;
         if (rd_req) begin
            pending_r <= 1'b1;
            base_r    <= baseaddr;
            line_r    <= line_length;
            col_r     <= col_length;
         end else if (grant_clr || abort_s) begin
            pending_r <= 1'b0;
         end else begin
            pending_r <= pending_r;
         end
      end
   end

   assign pending         = pending_r;
   assign cap_baseaddr    = base_r;
   assign cap_line_length = line_r;
   assign cap_col_length  = col_r;
   assign end_pulse       = end_pulse_s;

endmodule

// File: rtl/vdma_rd_arbiter.sv
// Round-robin arbiter sharing one DDR read controller between two VDMA channels.
// Define VDMA_ARB_WDOG_EN to add the BUSY watchdog and the wdog_err output.
module vdma_rd_arbiter
   import vdma_arb_pkg::*;
#(
   parameter int ADDR_BITS   = 25,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic                 pclk,
   input  logic                 prst,
   input  logic                 ch0_rd_req,
   input  logic [ADDR_BITS-1:0] ch0_baseaddr,
   input  logic [LINE_W-1:0]    ch0_line_length,
   input  logic [COL_W-1:0]     ch0_col_length,
   input  logic                 ch0_req_end,
   input  logic                 ch0_rd_data_en,
   output logic                 ch0_fifo_empty,
   input  logic                 ch1_rd_req,
   input  logic [ADDR_BITS-1:0] ch1_baseaddr,
   input  logic [LINE_W-1:0]    ch1_line_length,
   input  logic [COL_W-1:0]     ch1_col_length,
   input  logic                 ch1_req_end,
   input  logic                 ch1_rd_data_en,
   output logic                 ch1_fifo_empty,
   output logic                 ddr_rd_req,
   output logic [ADDR_BITS-1:0] ddr_baseaddr,
   output logic [LINE_W-1:0]    ddr_line_length,
   output logic [COL_W-1:0]     ddr_col_length,
   output logic                 ddr_req_end,
   output logic                 ddr_rd_data_en,
   input  logic                 ddr_fifo_empty,
`ifdef VDMA_ARB_WDOG_EN
   output logic                 wdog_err,
`endif
   output logic [1:0]           grant,
   output logic                 busy
);

   arb_state_e           state_r, state_n_s;
   logic                 owner_r, last_r, busy_r;
   logic [1:0]           grant_r, grant_n_s;
   logic                 ddr_rd_req_r, ddr_req_end_r;
   logic [ADDR_BITS-1:0] ddr_base_r;
   logic [LINE_W-1:0]    ddr_line_r;
   logic [COL_W-1:0]     ddr_col_r;

   logic [NUM_CH-1:0]    pend_s, end_pulse_s, is_owner_s, grant_clr_s;
   logic [ADDR_BITS-1:0] cap0_base_s, cap1_base_s;
   logic [LINE_W-1:0]    cap0_line_s, cap1_line_s;
   logic [COL_W-1:0]     cap0_col_s, cap1_col_s;
   logic                 sel_s, load_s, in_busy_s, owner_pop_s, owner_end_s, wdog_to_s;

   assign is_owner_s  = {busy_r & owner_r, busy_r & ~owner_r};
   assign in_busy_s   = (state_r == ST_BUSY);
   assign owner_pop_s = owner_r ? ch1_rd_data_en : ch0_rd_data_en;
   assign owner_end_s = owner_r ? end_pulse_s[1] : end_pulse_s[0];

   vdma_arb_chan_latch #(.ADDR_BITS(ADDR_BITS)) u_ch0 (
      .pclk(pclk), .prst(prst), .rd_req(ch0_rd_req), .baseaddr(ch0_baseaddr),
      .line_length(ch0_line_length), .col_length(ch0_col_length),
      .req_end(ch0_req_end), .is_owner(is_owner_s[0]), .grant_clr(grant_clr_s[0]),
      .pending(pend_s[0]), .cap_baseaddr(cap0_base_s), .cap_line_length(cap0_line_s),
      .cap_col_length(cap0_col_s), .end_pulse(end_pulse_s[0])
   );

   vdma_arb_chan_latch #(.ADDR_BITS(ADDR_BITS)) u_ch1 (
      .pclk(pclk), .prst(prst), .rd_req(ch1_rd_req), .baseaddr(ch1_baseaddr),
      .line_length(ch1_line_length), .col_length(ch1_col_length),
      .req_end(ch1_req_end), .is_owner(is_owner_s[1]), .grant_clr(grant_clr_s[1]),
      .pending(pend_s[1]), .cap_baseaddr(cap1_base_s), .cap_line_length(cap1_line_s),
      .cap_col_length(cap1_col_s), .end_pulse(end_pulse_s[1])
   );

   // Round-robin pick: on a tie the channel not granted last wins.
   always_comb begin
      sel_s = 1'b0;
      if (pend_s == 2'b11) begin
         sel_s = ~last_r;
      end else if (pend_s[0]) begin
         sel_s = 1'b0;
      end else begin
         sel_s = 1'b1;
      end
   end

   // Next-state and next-output decode.
   always_comb begin
      state_n_s   = state_r;
      grant_clr_s = 2'b00;
      load_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (|pend_s) begin
               state_n_s   = ST_ISSUE;
               load_s      = 1'b1;
               grant_clr_s = sel_s ? 2'b10 : 2'b01;
            end else begin
               state_n_s = ST_IDLE;
            end
         end
         ST_ISSUE:   state_n_s = ST_BUSY;
         ST_BUSY: begin
            if (owner_end_s || wdog_to_s) begin
               state_n_s = ST_RELEASE;
            end else begin
               state_n_s = ST_BUSY;
            end
         end
         ST_RELEASE: state_n_s = ST_IDLE;
         default:    state_n_s = ST_IDLE;
      endcase
      if ((state_n_s == ST_ISSUE) || (state_n_s == ST_BUSY)) begin
         grant_n_s = (load_s ? sel_s : owner_r) ? 2'b10 : 2'b01;
      end else begin
         grant_n_s = 2'b00;
      end
   end

   // State and registered outputs; reset aborts any frame without ddr_req_end.
   always_ff @(posedge pclk) begin
      if (prst) begin
         state_r       <= ST_IDLE;
         owner_r       <= 1'b0;
         last_r        <= 1'b1;
         busy_r        <= 1'b0;
         grant_r       <= 2'b00;
         ddr_rd_req_r  <= 1'b0;
         ddr_req_end_r <= 1'b0;
         ddr_base_r    <= '0;
         ddr_line_r    <= '0;
         ddr_col_r     <= '0;
      end else begin
         state_r       <= state_n_s;
         ddr_rd_req_r  <= load_s;
         ddr_req_end_r <= (state_n_s == ST_RELEASE);
         busy_r        <= (grant_n_s != 2'b00);
         grant_r       <= grant_n_s;
         if (load_s) begin
            owner_r    <= sel_s;
            ddr_base_r <= sel_s ? cap1_base_s : cap0_base_s;
            ddr_line_r <= sel_s ? cap1_line_s : cap0_line_s;
            ddr_col_r  <= sel_s ? cap1_col_s  : cap0_col_s;
         end else begin
            owner_r    <= owner_r;
            ddr_base_r <= ddr_base_r;
            ddr_line_r <= ddr_line_r;
            ddr_col_r  <= ddr_col_r;
         end
         if (state_r == ST_RELEASE) begin
            last_r <= owner_r;
         end else begin
            last_r <= last_r;
         end
      end
   end

`ifdef VDMA_ARB_WDOG_EN
   localparam int WDOG_W = $clog2(TIMEOUT_CYC + 1);
   logic [WDOG_W-1:0] wdog_cnt_r;
   logic              wdog_err_r;

   assign wdog_to_s = in_busy_s & ~owner_pop_s & (wdog_cnt_r == WDOG_W'(TIMEOUT_CYC - 1));

   // Counts consecutive BUSY cycles without an owner pop; error flag is sticky.
   always_ff @(posedge pclk) begin
      if (prst) begin
         wdog_cnt_r <= '0;
         wdog_err_r <= 1'b0;
      end else begin
         if (in_busy_s && !owner_pop_s) begin
            wdog_cnt_r <= wdog_cnt_r + WDOG_W'(1);
         end else begin
            wdog_cnt_r <= '0;
         end
         wdog_err_r <= wdog_err_r | wdog_to_s;
      end
   end

   assign wdog_err = wdog_err_r;
`else
   assign wdog_to_s = 1'b0;
`endif

   assign ddr_rd_req      = ddr_rd_req_r;
   assign ddr_req_end     = ddr_req_end_r;
   assign ddr_baseaddr    = ddr_base_r;
   assign ddr_line_length = ddr_line_r;
   assign ddr_col_length  = ddr_col_r;
   assign grant           = grant_r;
   assign busy            = busy_r;
   assign ddr_rd_data_en  = in_busy_s & owner_pop_s;
   assign ch0_fifo_empty  = (in_busy_s && !owner_r) ? ddr_fifo_empty : 1'b1;
   assign ch1_fifo_empty  = (in_busy_s &&  owner_r) ? ddr_fifo_empty : 1'b1;

endmodule

// File: doc/vdma_rd_arbiter.md
VDMA_RD_ARBITER -- requirements
Module: vdma_rd_arbiter

Interface
REQ-001 Parameter ADDR_BITS, default 25, DDR word address width.
REQ-002 Parameter TIMEOUT_CYC, default 65535, watchdog limit in pclk cycles; used only with VDMA_ARB_WDOG_EN.
REQ-003 pclk  in  1  single clock; all logic on rising edge.
REQ-004 prst  in  1  reset, synchronous, active-high.
REQ-005 chN_rd_req  in  1  (N=0,1) one-cycle frame read request.
REQ-006 chN_baseaddr  in  ADDR_BITS  frame base address, sampled with chN_rd_req.
REQ-007 chN_line_length  in  24  64-bit words per line, sampled with chN_rd_req.
REQ-008 chN_col_length  in  12  lines per frame, sampled with chN_rd_req.
REQ-009 chN_req_end  in  1  frame read finished; level or pulse, first high cycle counts.
REQ-010 chN_rd_data_en  in  1  channel FIFO pop.
REQ-011 chN_fifo_empty  out  1  read FIFO empty as seen by channel N.
REQ-012 ddr_rd_req / ddr_baseaddr / ddr_line_length / ddr_col_length / ddr_req_end  out  1/ADDR_BITS/24/12/1  shared DDR read-controller request port.
REQ-013 ddr_rd_data_en  out  1  forwarded pop; ddr_fifo_empty  in  1  controller FIFO empty.
REQ-014 grant  out  2  one-hot owner; 2'b00 when none.  busy  out  1  owner present.

Function
REQ-015 Each channel has a pending flag plus captured address/lengths, set on chN_rd_req; a new chN_rd_req while pending overwrites the captured values.
REQ-016 FSM states: IDLE, ISSUE, BUSY, RELEASE.
REQ-017 IDLE: if any pending, go to ISSUE and select an owner round-robin; the channel not granted last wins a tie; after reset ch0 has priority.
REQ-018 ISSUE, one cycle: ddr_rd_req=1, grant set, owner pending cleared, ddr_baseaddr/lengths loaded from owner capture and held until the next ISSUE; next state BUSY.
REQ-019 BUSY: ddr_rd_data_en = owner chN_rd_data_en; owner chN_fifo_empty = ddr_fifo_empty; on owner chN_req_end go to RELEASE.
REQ-020 RELEASE, one cycle: ddr_req_end=1, grant=0, last-owner pointer updated; next state IDLE, so there is at least one idle cycle between frames.
REQ-021 Non-owners always see chN_fifo_empty=1; their chN_rd_data_en is ignored.
REQ-022 chN_req_end from a non-owner clears that channel's pending flag (abort) and does not affect the FSM.
REQ-023 chN_rd_req from the owner during BUSY sets its pending flag for the next frame and does not affect the current grant.
REQ-024 Simultaneous chN_rd_req and chN_req_end on the owner: the end wins for the FSM and the request latches as pending.
REQ-025 Outside BUSY: ddr_rd_data_en=0 and both chN_fifo_empty=1.
REQ-026 Request-to-ddr_rd_req latency: 2 cycles from an IDLE start (capture, IDLE->ISSUE).

Reset
REQ-027 Reset state:
  - FSM in IDLE; pending flags cleared; pointer favours ch0.
  - ddr_rd_req, ddr_req_end, ddr_rd_data_en, grant and busy are 0.
  - ddr_baseaddr and both lengths are 0; chN_fifo_empty is 1.
REQ-028 Reset in any state aborts the frame with no ddr_req_end.

Configuration
REQ-029 Macro VDMA_ARB_WDOG_EN defined: a BUSY watchdog counts cycles with no owner chN_rd_data_en; at TIMEOUT_CYC it forces RELEASE (ddr_req_end pulses) and sets the sticky output wdog_err, cleared only by reset. The counter reloads on every pop.
REQ-030 Macro not defined: no counter, no wdog_err port; BUSY waits indefinitely.

Structure
REQ-031 Package vdma_arb_pkg holds the FSM state encoding, the channel count constant (2) and the TIMEOUT_CYC default.
REQ-032 Sub-module vdma_arb_chan_latch holds one channel's pending flag and captured fields; it is instantiated twice.

Verification
REQ-033 ch0_rd_req with base 0x0100000, line 0x000168, col 0x2D0 -> ddr_rd_req pulses 2 cycles later with the same values and grant=01.
REQ-034 ch0 and ch1 requests in the same cycle after reset -> ch0 granted first; after ch0_req_end, RELEASE, IDLE, then ch1 ISSUE with grant=10.
REQ-035 With ch1 as owner, ch0_rd_data_en toggling -> ddr_rd_data_en follows only ch1_rd_data_en and ch0_fifo_empty stays 1.
REQ-036 ch1 pending, then ch1_req_end while ch0 owns -> ch1 is never granted after ch0 releases.
REQ-037 prst asserted in BUSY -> next cycle all outputs are at reset values and no ddr_req_end is seen.
REQ-038 With VDMA_ARB_WDOG_EN and TIMEOUT_CYC=16, owner idle 16 cycles -> ddr_req_end pulse, wdog_err=1 and FSM back in IDLE.
